pad_trigger_gate: RTL and testbench
===================================

Name: pad_trigger_gate

Overview:
- Sits directly downstream of the pad hit generator and consumes its qualified hit strobe (`pad_hited_clear`).
- Applies a programmable coincidence window and a minimum hit count, then issues a timestamped trigger over a valid/ready handshake to the trigger readout stage.
- Enforces programmable deadtime after each trigger and keeps trigger, miss and lost counters for monitoring.

Parameters:
TS_W, 12, free-running timestamp width (bits)
WIN_W, 4, coincidence window config width
DT_W, 8, deadtime config width
HIT_W, 3, min-hit config / hit counter width
CNT_W, 16, width of trigger/miss/lost counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
trigger_enable  in  1  gate enable; low forces IDLE (see rules)
pad_hited_clear  in  1  qualified pad hit strobe, one per hit cycle
window_cfg  in  WIN_W  coincidence window length in cycles after first hit
min_hits_cfg  in  HIT_W  hits required within window (0 treated as 1)
deadtime_cfg  in  DT_W  deadtime cycles after accepted trigger
trig_valid  out  1  trigger available
trig_ready  in  1  downstream accepts trigger
trig_ts  out  TS_W  timestamp of first hit of the triggering group
trig_hits  out  HIT_W  hits counted in the group
busy  out  1  high in WINDOW, ISSUE, DEAD
trig_count  out  CNT_W  accepted triggers, wraps
miss_count  out  CNT_W  windows expired below threshold, saturating
lost_count  out  CNT_W  hits ignored in ISSUE/DEAD, saturating

Behaviour:
- Reset: every output is 0; state is IDLE; timestamp is 0.
- Timestamp counter: increments every clk (not gated by enable); wraps 2^TS_W-1 -> 0.
- Config sampling: config inputs are sampled on the transition that uses them.
  - window_cfg and min_hits_cfg are sampled on the first hit.
  - deadtime_cfg is sampled on the handshake.
- IDLE: when trigger_enable=1 -> ARMED next cycle.
- ARMED: on pad_hited_clear=1:
  - Latch trig_ts = current timestamp.
  - Set hit_cnt = 1 and win_cnt = window_cfg.
  - If effective min_hits <= 1 -> ISSUE; else -> WINDOW.
- WINDOW:
  - Each pad_hited_clear increments hit_cnt, saturating at 2^HIT_W-1.
  - win_cnt decrements each cycle.
  - If hit_cnt (including this cycle's hit) >= min_hits -> ISSUE.
  - Else if win_cnt == 0 -> ARMED, miss_count++.
  - A hit on the final window cycle counts.
  - window_cfg = 0: only the first-hit cycle counts, so the next cycle expires unless the threshold is already met.
- ISSUE:
  - trig_valid = 1; trig_ts and trig_hits are held stable.
  - trig_valid stays asserted until trig_valid & trig_ready.
  - On handshake: trig_count++; if deadtime_cfg == 0 -> ARMED, else -> DEAD with dead_cnt = deadtime_cfg.
  - trig_valid drops on the cycle after the handshake.
- DEAD: dead_cnt decrements; at 1 -> ARMED. DEAD lasts exactly deadtime_cfg cycles.
- Lost hits: a pad_hited_clear in ISSUE or DEAD increments lost_count. The lost hit is not counted toward any group.
- Latency: with min_hits = 1, a hit in cycle N gives trig_valid at N+1. The earliest next acceptable hit is at handshake + deadtime_cfg + 1.
- trigger_enable deassert:
  - In ARMED, WINDOW or DEAD: -> IDLE next cycle; a partial group is discarded without incrementing miss_count.
  - In ISSUE: the handshake completes first, then -> IDLE.
  - Hits in IDLE are ignored and not counted.
- Reset mid-operation: immediate return to reset values, including a pending trig_valid.

Optional Feature:
Macro: PAD_TRIG_RATE_MON_EN.
- Defined:
  - Adds output `rate_count` [CNT_W-1:0]: accepted triggers per 2^16-cycle interval, using an internal interval counter.
  - At interval rollover, rate_count is loaded with the accumulated count and the accumulator restarts; a handshake on the rollover cycle counts in the new interval.
  - rate_count resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `pad_trig_pkg` holds:
  - state enum IDLE / ARMED / WINDOW / ISSUE / DEAD;
  - default width constants;
  - saturating-increment function used by miss and lost counters.
- Sub-module `pad_trig_sat_counter` (width param, inc, out, saturate/wrap select), instantiated for trig/miss/lost counters.
- FSM, window and deadtime counters live in the top module.

Test Plan:
- enable=1, min_hits=1, deadtime=3, ready=1, hit at ts=0x010 -> trig_valid one cycle later, trig_ts=0x010, trig_hits=1, trig_count=1; hits during the following 3 DEAD cycles -> lost_count=3, no trigger.
- min_hits=3, window=4, hits at first, +2, +4 -> trigger with trig_hits=3 (last-cycle hit counts); hits at first, +2 only -> no trigger, miss_count=1, back to ARMED.
- ready held low 10 cycles in ISSUE -> trig_valid, trig_ts and trig_hits stable for 10 cycles; 5 hits meanwhile -> lost_count=5; ready=1 -> single trig_count increment.
- Timestamp wrap: hit at ts=0xFFF with min_hits=2 and second hit at ts=0x001 -> trig_ts=0xFFF.
- enable dropped mid-WINDOW -> IDLE, miss_count unchanged; enable dropped during ISSUE -> trig_valid held until ready, then IDLE; rst_n pulsed during ISSUE -> all outputs 0 immediately.
- With PAD_TRIG_RATE_MON_EN defined: 7 accepted triggers within one 65536-cycle interval -> rate_count=7 after rollover.

Source files
------------

// File: rtl/pad_trig_pkg.sv
// Shared types, default widths and helpers for the pad trigger gate.
package pad_trig_pkg;

    localparam int TS_W_DEF  = 12;
    localparam int WIN_W_DEF = 4;
    localparam int DT_W_DEF  = 8;
    localparam int HIT_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WINDOW = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DEAD   = 3'd4
    } state_t;

    // Increment that sticks at max_v; callers zero-extend narrower counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pad_trig_sat_counter.sv
// Monitoring event counter: saturating (SAT=1) or wrapping (SAT=0), width W < 32.
module pad_trig_sat_counter
    import pad_trig_pkg::*;
#(
    parameter int W   = CNT_W_DEF,
    parameter bit SAT = 1'b1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [31:0] MAX_V = 32'((64'd1 << W) - 64'd1);

    logic [31:0]  sat_nxt;
    logic [W-1:0] nxt;
    logic         unused_sat_hi;

    assign sat_nxt       = sat_inc(32'(cnt), MAX_V);
    assign unused_sat_hi = |sat_nxt[31:W];
    assign nxt           = SAT ? sat_nxt[W-1:0] : cnt + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/pad_trigger_gate.sv
// Coincidence trigger gate behind the pad hit generator: window, min-hit threshold,
// valid/ready trigger issue, deadtime. Optional rate monitor under PAD_TRIG_RATE_MON_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | gate disabled, hits ignored
//   ST_ARMED  | waiting for the first hit of a group
//   ST_WINDOW | counting hits until threshold or window expiry
//   ST_ISSUE  | trig_valid high, waiting for trig_ready
//   ST_DEAD   | post-trigger deadtime, hits are lost
module pad_trigger_gate
    import pad_trig_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int WIN_W = WIN_W_DEF,
    parameter int DT_W  = DT_W_DEF,
    parameter int HIT_W = HIT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger_enable,
    input  logic             pad_hited_clear,
    input  logic [WIN_W-1:0] window_cfg,
    input  logic [HIT_W-1:0] min_hits_cfg,
    input  logic [DT_W-1:0]  deadtime_cfg,
    output logic             trig_valid,
    input  logic             trig_ready,
    output logic [TS_W-1:0]  trig_ts,
    output logic [HIT_W-1:0] trig_hits,
    output logic             busy,
    output logic [CNT_W-1:0] trig_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] lost_count
`ifdef PAD_TRIG_RATE_MON_EN
   ,output logic [CNT_W-1:0] rate_count
`endif
);

    state_t           state_q, state_d;
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  trig_ts_q, trig_ts_d;
    logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [HIT_W-1:0] min_q, min_d;
    logic [HIT_W-1:0] eff_min, hits_inc;
    logic [WIN_W-1:0] win_q, win_d;
    logic [DT_W-1:0]  dead_q, dead_d;
    logic             trig_inc, miss_inc, lost_inc;

    assign eff_min  = (min_hits_cfg == '0) ? HIT_W'(1) : min_hits_cfg;
    assign hits_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + HIT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            trig_ts_q <= '0;
            hit_cnt_q <= '0;
            min_q     <= '0;
            win_q     <= '0;
            dead_q    <= '0;
        end else begin
            state_q   <= state_d;
            trig_ts_q <= trig_ts_d;
            hit_cnt_q <= hit_cnt_d;
            min_q     <= min_d;
            win_q     <= win_d;
            dead_q    <= dead_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        trig_ts_d = trig_ts_q;
        hit_cnt_d = hit_cnt_q;
        min_d     = min_q;
        win_d     = win_q;
        dead_d    = dead_q;
        trig_inc  = 1'b0;
        miss_inc  = 1'b0;
        lost_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger_enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!trigger_enable) begin
                    state_d = ST_IDLE;
                end else if (pad_hited_clear) begin
                    trig_ts_d = ts_q;
                    hit_cnt_d = HIT_W'(1);
                    win_d     = window_cfg;
                    min_d     = eff_min;
                    state_d   = (eff_min <= HIT_W'(1)) ? ST_ISSUE : ST_WINDOW;
                end
            end
            ST_WINDOW: begin
                // win_q == 0 marks the expiry cycle; a hit there is not part of the group
                if (!trigger_enable) begin
                    state_d = ST_IDLE;
                end else if (win_q == '0) begin
                    miss_inc = 1'b1;
                    state_d  = ST_ARMED;
                end else begin
                    if (pad_hited_clear) hit_cnt_d = hits_inc;
                    if (hit_cnt_d >= min_q) state_d = ST_ISSUE;
                    else                    win_d   = win_q - WIN_W'(1);
                end
            end
            ST_ISSUE: begin
                lost_inc = pad_hited_clear;
                if (trig_ready) begin
                    trig_inc = 1'b1;
                    if (!trigger_enable) begin
                        state_d = ST_IDLE;
                    end else if (deadtime_cfg == '0) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_DEAD;
                        dead_d  = deadtime_cfg;
                    end
                end
            end
            ST_DEAD: begin
                lost_inc = pad_hited_clear;
                if (!trigger_enable)           state_d = ST_IDLE;
                else if (dead_q <= DT_W'(1))   state_d = ST_ARMED;
                else                           dead_d  = dead_q - DT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign trig_valid = (state_q == ST_ISSUE);
    assign busy       = (state_q == ST_WINDOW) || (state_q == ST_ISSUE) || (state_q == ST_DEAD);
    assign trig_ts    = trig_ts_q;
    assign trig_hits  = hit_cnt_q;

    pad_trig_sat_counter #(.W(CNT_W), .SAT(1'b0)) u_trig_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (trig_inc),
        .cnt   (trig_count)
    );

    pad_trig_sat_counter #(.W(CNT_W), .SAT(1'b1)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .cnt   (miss_count)
    );

    pad_trig_sat_counter #(.W(CNT_W), .SAT(1'b1)) u_lost_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lost_inc),
        .cnt   (lost_count)
    );

`ifdef PAD_TRIG_RATE_MON_EN
    logic [15:0]      ivl_q;
    logic [CNT_W-1:0] rate_acc_q;

    // A handshake on the rollover cycle seeds the new interval's accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_q      <= '0;
            rate_acc_q <= '0;
            rate_count <= '0;
        end else begin
            ivl_q <= ivl_q + 16'd1;
            if (ivl_q == 16'hFFFF) begin
                rate_count <= rate_acc_q;
                rate_acc_q <= CNT_W'(trig_inc);
            end else begin
                rate_acc_q <= rate_acc_q + CNT_W'(trig_inc);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pad_trigger_gate.sv
// Self-checking bench for pad_trigger_gate: directed scenarios plus random traffic vs. an event-time model.
module tb_pad_trigger_gate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger_enable = 1'b0;
    logic        pad_hited_clear = 1'b0;
    logic [3:0]  window_cfg = '0;
    logic [2:0]  min_hits_cfg = '0;
    logic [7:0]  deadtime_cfg = '0;
    logic        trig_ready = 1'b0;
    logic        trig_valid;
    logic [11:0] trig_ts;
    logic [2:0]  trig_hits;
    logic        busy;
    logic [15:0] trig_count, miss_count, lost_count;
`ifdef PAD_TRIG_RATE_MON_EN
    logic [15:0] rate_count;
`endif

    always #5 clk = ~clk;

    pad_trigger_gate dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trigger_enable  (trigger_enable),
        .pad_hited_clear (pad_hited_clear),
        .window_cfg      (window_cfg),
        .min_hits_cfg    (min_hits_cfg),
        .deadtime_cfg    (deadtime_cfg),
        .trig_valid      (trig_valid),
        .trig_ready      (trig_ready),
        .trig_ts         (trig_ts),
        .trig_hits       (trig_hits),
        .busy            (busy),
        .trig_count      (trig_count),
        .miss_count      (miss_count),
        .lost_count      (lost_count)
`ifdef PAD_TRIG_RATE_MON_EN
       ,.rate_count      (rate_count)
`endif
    );

    int compared = 0;
    int mism = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Event-time model: absolute cycle numbers for window end and deadtime end.
    typedef struct {
        int now;
        bit live;
        bit pending;
        bit open_g;
        int opened_at;
        int win_len;
        int need;
        int hits;
        int resume_at;
        int ts;
        int first_ts;
        int trigs;
        int miss;
        int lost;
        int ivl;
        int acc;
        int rate;
    } mdl_t;

    mdl_t m;

    function automatic int sat16(input int v);
        return (v >= 65535) ? v : v + 1;
    endfunction

    function automatic mdl_t step(input mdl_t s, input bit en, input bit hit, input bit rdy,
                                  input int wcfg, input int mcfg, input int dcfg);
        mdl_t n = s;
        bit hs = 1'b0;
        if (!s.live) begin
            if (en) n.live = 1'b1;
        end else if (s.pending) begin
            if (hit) n.lost = sat16(s.lost);
            if (rdy) begin
                hs = 1'b1;
                n.pending = 1'b0;
                n.trigs = (s.trigs + 1) % 65536;
                if (!en) n.live = 1'b0;
                else     n.resume_at = s.now + dcfg + 1;
            end
        end else if (s.now < s.resume_at) begin
            if (hit) n.lost = sat16(s.lost);
            if (!en) begin
                n.live = 1'b0;
                n.resume_at = 0;
            end
        end else if (s.open_g) begin
            if (!en) begin
                n.open_g = 1'b0;
                n.live = 1'b0;
            end else if (s.now > s.opened_at + s.win_len) begin
                n.open_g = 1'b0;
                n.miss = sat16(s.miss);
            end else begin
                if (hit) n.hits = (s.hits + 1 > 7) ? 7 : s.hits + 1;
                if (n.hits >= s.need) begin
                    n.open_g = 1'b0;
                    n.pending = 1'b1;
                end
            end
        end else begin
            if (!en) begin
                n.live = 1'b0;
            end else if (hit) begin
                n.first_ts = s.ts;
                n.hits = 1;
                n.need = (mcfg == 0) ? 1 : mcfg;
                n.win_len = wcfg;
                n.opened_at = s.now;
                if (n.need <= 1) n.pending = 1'b1;
                else             n.open_g = 1'b1;
            end
        end
        if (s.ivl == 65535) begin
            n.rate = s.acc;
            n.acc = int'(hs);
        end else begin
            n.acc = s.acc + int'(hs);
        end
        n.ivl = (s.ivl + 1) % 65536;
        n.now = s.now + 1;
        n.ts = (s.ts + 1) % 4096;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default: 0};
        else        m <= step(m, trigger_enable, pad_hited_clear, trig_ready,
                              int'(window_cfg), int'(min_hits_cfg), int'(deadtime_cfg));
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("trig_valid", 32'(trig_valid), 32'(m.pending));
            chk("busy", 32'(busy), 32'(m.pending || m.open_g || (m.live && m.now < m.resume_at)));
            chk("trig_count", 32'(trig_count), 32'(m.trigs));
            chk("miss_count", 32'(miss_count), 32'(m.miss));
            chk("lost_count", 32'(lost_count), 32'(m.lost));
            if (m.pending) begin
                chk("trig_ts", 32'(trig_ts), 32'(m.first_ts));
                chk("trig_hits", 32'(trig_hits), 32'(m.hits));
            end
`ifdef PAD_TRIG_RATE_MON_EN
            chk("rate_count", 32'(rate_count), 32'(m.rate));
`endif
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(trig_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_trig_count"}, 32'(trig_count), 32'd0);
        chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
        chk({tag, "_lost_count"}, 32'(lost_count), 32'd0);
        chk({tag, "_trig_ts"}, 32'(trig_ts), 32'd0);
        chk({tag, "_trig_hits"}, 32'(trig_hits), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        trigger_enable = 1'b0;
        pad_hited_clear = 1'b0;
        trig_ready = 1'b0;
        window_cfg = '0;
        min_hits_cfg = '0;
        deadtime_cfg = '0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic wait_ts(input int target);
        int k = 0;
        while (m.ts != target && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (m.ts != target) begin
            compared++;
            mism++;
            $display("FAIL wait_ts: timed out at ts %0h, required %0h", m.ts, target);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // single-hit trigger, then hits lost during 3 deadtime cycles
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd1; deadtime_cfg = 8'd3; trig_ready = 1'b1;
        wait_ts(12'h010);
        pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0;
        chk("s1_valid", 32'(trig_valid), 32'd1);
        chk("s1_ts", 32'(trig_ts), 32'h010);
        chk("s1_hits", 32'(trig_hits), 32'd1);
        @(negedge clk);
        chk("s1_count", 32'(trig_count), 32'd1);
        pad_hited_clear = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); pad_hited_clear = 1'b0;
        chk("s1_lost", 32'(lost_count), 32'd3);
        chk("s1_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("s1_no_retrig", 32'(trig_valid), 32'd0);
        chk("s1_count2", 32'(trig_count), 32'd1);

        // window of 4: hits at +0,+2,+4 trigger; hits at +0,+2 only miss
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd3; window_cfg = 4'd4; trig_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pad_hited_clear = (i % 2 == 0);
            @(negedge clk);
        end
        pad_hited_clear = 1'b0;
        chk("s2_valid", 32'(trig_valid), 32'd1);
        chk("s2_hits", 32'(trig_hits), 32'd3);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            pad_hited_clear = (i == 0 || i == 2);
            @(negedge clk);
        end
        pad_hited_clear = 1'b0;
        chk("s2_busy_exp", 32'(busy), 32'd0);
        chk("s2_miss", 32'(miss_count), 32'd1);
        chk("s2_trigs", 32'(trig_count), 32'd1);

        // ready held low for 10 cycles with 5 lost hits
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd0; trig_ready = 1'b0;
        wait_ts(12'h020);
        pad_hited_clear = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("s3_valid", 32'(trig_valid), 32'd1);
            chk("s3_ts", 32'(trig_ts), 32'h020);
            chk("s3_hits", 32'(trig_hits), 32'd1);
            pad_hited_clear = (i < 5);
            @(negedge clk);
        end
        pad_hited_clear = 1'b0; trig_ready = 1'b1;
        @(negedge clk);
        chk("s3_lost", 32'(lost_count), 32'd5);
        chk("s3_count", 32'(trig_count), 32'd1);
        chk("s3_valid_drop", 32'(trig_valid), 32'd0);
        @(negedge clk);
        chk("s3_count2", 32'(trig_count), 32'd1);

        // timestamp wrap inside a group
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd2; window_cfg = 4'd4; trig_ready = 1'b1;
        wait_ts(12'hFFF);
        pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0;
        @(negedge clk); pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0;
        chk("s4_valid", 32'(trig_valid), 32'd1);
        chk("s4_ts", 32'(trig_ts), 32'hFFF);
        chk("s4_hits", 32'(trig_hits), 32'd2);

        // enable dropped mid-window, in ISSUE, then reset during ISSUE
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd3; window_cfg = 4'd8; trig_ready = 1'b1;
        repeat (2) @(negedge clk);
        pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0; trigger_enable = 1'b0;
        @(negedge clk);
        chk("s5_idle_busy", 32'(busy), 32'd0);
        pad_hited_clear = 1'b1;
        repeat (12) @(negedge clk);
        pad_hited_clear = 1'b0;
        chk("s5_miss", 32'(miss_count), 32'd0);
        chk("s5_lost", 32'(lost_count), 32'd0);
        chk("s5_trigs", 32'(trig_count), 32'd0);
        trigger_enable = 1'b1; min_hits_cfg = 3'd1; trig_ready = 1'b0;
        @(negedge clk); pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0; trigger_enable = 1'b0;
        chk("s5_issue", 32'(trig_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s5_hold", 32'(trig_valid), 32'd1);
        end
        trig_ready = 1'b1;
        @(negedge clk); trig_ready = 1'b0;
        chk("s5_drop", 32'(trig_valid), 32'd0);
        chk("s5_idle2", 32'(busy), 32'd0);
        chk("s5_count", 32'(trig_count), 32'd1);
        trigger_enable = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b1;
        @(negedge clk); pad_hited_clear = 1'b0;
        chk("s5_issue2", 32'(trig_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        do_reset();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            trigger_enable  = ($urandom_range(0, 19) != 0);
            pad_hited_clear = ($urandom_range(0, 9) < 3);
            trig_ready      = ($urandom_range(0, 9) < 6);
            window_cfg      = 4'($urandom_range(0, 15));
            min_hits_cfg    = 3'($urandom_range(0, 7));
            deadtime_cfg    = 8'($urandom_range(0, 12));
            @(negedge clk);
        end

`ifdef PAD_TRIG_RATE_MON_EN
        do_reset();
        trigger_enable = 1'b1; min_hits_cfg = 3'd1; deadtime_cfg = 8'd0; trig_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); pad_hited_clear = 1'b1;
            @(negedge clk); pad_hited_clear = 1'b0;
            repeat (2) @(negedge clk);
        end
        begin
            int k = 0;
            while (m.now < 65537 && k < 70000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rate_7", 32'(rate_count), 32'd7);
`endif

        trigger_enable = 1'b0;
        pad_hited_clear = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
